fetch_queue: RTL and testbench

Instruction fetch queue between the instruction memory and the decoder. It buffers fetched instruction pairs (slot 1 and slot 2, both 32-bit) with their PC, so the two sides are decoupled. The decoder may consume a whole pair or only slot 1; a partly consumed pair is re-presented with slot 2 moved into slot 1. The queue is emptied on a branch redirect.

---
 rtl/fetch_queue_pkg.sv | 23 ++
 rtl/fq_ram.sv | 33 +++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
//------------------------------------------------------------------------------
// fetch_queue_pkg : shared constants and entry type for the fetch queue
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_queue_pkg;

    localparam logic [31:0] C_NOP = 32'h0000_0000;

    localparam logic [1:0] TAKE_NONE = 2'b00;
    localparam logic [1:0] TAKE_ONE  = 2'b01;
    localparam logic [1:0] TAKE_BOTH = 2'b10;

    typedef struct packed {
        logic [31:0] inst1;
        logic [31:0] inst2;
        logic [31:0] pc;
    } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fq_ram.sv
//------------------------------------------------------------------------------
// fq_ram : DEPTH x 96-bit entry storage, synchronous write, combinational read
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fq_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  fq_entry_t       wr_data,
    input  logic [AW-1:0]   rd_addr,
    output fq_entry_t       rd_data
);

    fq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// fetch_queue : instruction-pair queue between fetch and decode, with
//               half-pair consumption and flush on branch redirect
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = C_NOP
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_inst1,
    input  logic [31:0]               in_inst2,
    input  logic [31:0]               in_pc,
    output logic                      out_valid,
    output logic [31:0]               out_inst1,
    output logic [31:0]               out_inst2,
    output logic [31:0]               out_pc,
    input  logic [1:0]                take,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_half;

    logic          w_push;
    logic          w_pop;
    logic          w_set_half;
    fq_entry_t     w_wr_data;
    fq_entry_t     w_head;

    assign in_ready  = (r_count < C_FULL);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && ((take == TAKE_BOTH) || ((take == TAKE_ONE) && r_half));
    assign w_set_half = out_valid && (take == TAKE_ONE) && !r_half;

    assign w_wr_data = '{inst1: in_inst1, inst2: in_inst2, pc: in_pc};

    fq_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_push && !flush && !reset),
        .wr_addr (r_wr_ptr),
        .wr_data (w_wr_data),
        .rd_addr (r_rd_ptr),
        .rd_data (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_half   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_half   <= 1'b0;
            end else if (w_set_half) begin
                r_half   <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A half-consumed head shifts slot 2 into slot 1 and advances the PC.
    always_comb begin
        out_inst1 = NOP;
        out_inst2 = NOP;
        out_pc    = 32'h0;
        if (out_valid) begin
            if (r_half) begin
                out_inst1 = w_head.inst2;
                out_pc    = w_head.pc + 32'd4;
            end else begin
                out_inst1 = w_head.inst1;
                out_inst2 = w_head.inst2;
                out_pc    = w_head.pc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//------------------------------------------------------------------------------
// tb_fetch_queue : directed self-checking bench for fetch_queue
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst1 = '0;
    logic [31:0] in_inst2 = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic [31:0] out_inst1;
    logic [31:0] out_inst2;
    logic [31:0] out_pc;
    logic [1:0]  take = 2'b00;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(4), .NOP(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst1  (in_inst1),
        .in_inst2  (in_inst2),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_inst1 (out_inst1),
        .out_inst2 (out_inst2),
        .out_pc    (out_pc),
        .take      (take),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_pair(input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst1 = i1;
        in_inst2 = i2;
        in_pc    = pc;
    endtask

    initial begin
        // reset then idle
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_inst1", out_inst1, 32'h0);
        chk("rst_inst2", out_inst2, 32'h0);
        chk("rst_pc", out_pc, 32'h0);

        // single pair, split consumption
        drive_pair(32'hA1A1_0001, 32'hA2A2_0002, 32'h0000_0100);
        step();
        in_valid = 1'b0;
        chk("a_valid", 32'(out_valid), 32'd1);
        chk("a_inst1", out_inst1, 32'hA1A1_0001);
        chk("a_inst2", out_inst2, 32'hA2A2_0002);
        chk("a_pc", out_pc, 32'h0000_0100);
        take = 2'b01;
        step();
        chk("ah_inst1", out_inst1, 32'hA2A2_0002);
        chk("ah_inst2", out_inst2, 32'h0);
        chk("ah_pc", out_pc, 32'h0000_0104);
        chk("ah_count", 32'(count), 32'd1);
        step();
        take = 2'b00;
        chk("a_done_valid", 32'(out_valid), 32'd0);
        chk("a_done_inst1", out_inst1, 32'h0);

        // fill to full
        for (int i = 0; i < 4; i++) begin
            drive_pair(32'h1100_0000 + i, 32'h2200_0000 + i, 32'h0000_2000 + 32'(i * 8));
            step();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_head", out_inst1, 32'h1100_0000);
        drive_pair(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_0000);
        take = 2'b10;
        step();
        in_valid = 1'b0;
        chk("fullpop_count", 32'(count), 32'd3);
        chk("fullpop_head", out_inst1, 32'h1100_0001);
        chk("fullpop_pc", out_pc, 32'h0000_2008);
        step();
        step();
        chk("drain_head", out_inst1, 32'h1100_0003);
        step();
        chk("drain_count", 32'(count), 32'd0);

        // streaming across the wrap, one pair per cycle
        for (int i = 0; i < 10; i++) begin
            drive_pair(32'h3300_0000 + i, 32'h4400_0000 + i, 32'h0000_4000 + 32'(i * 8));
            take = 2'b10;
            step();
            chk("stream_inst1", out_inst1, 32'h3300_0000 + i);
            chk("stream_pc", out_pc, 32'h0000_4000 + 32'(i * 8));
            chk("stream_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        step();
        take = 2'b00;
        chk("stream_end_count", 32'(count), 32'd0);

        // flush mid-operation with a half-consumed head
        for (int i = 0; i < 3; i++) begin
            drive_pair(32'h5500_0000 + i, 32'h6600_0000 + i, 32'h0000_6000 + 32'(i * 8));
            step();
        end
        in_valid = 1'b0;
        take = 2'b01;
        step();
        chk("pre_flush_pc", out_pc, 32'h0000_6004);
        chk("pre_flush_inst1", out_inst1, 32'h6600_0000);
        flush = 1'b1;
        take = 2'b10;
        drive_pair(32'hBAD0_0001, 32'hBAD0_0002, 32'hBAD0_0000);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        take = 2'b00;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        drive_pair(32'h7700_0001, 32'h7700_0002, 32'h0000_8000);
        step();
        in_valid = 1'b0;
        chk("post_flush_inst1", out_inst1, 32'h7700_0001);
        chk("post_flush_inst2", out_inst2, 32'h7700_0002);
        chk("post_flush_pc", out_pc, 32'h0000_8000);
        chk("post_flush_count", 32'(count), 32'd1);
        take = 2'b10;
        step();
        take = 2'b00;

        // pc wrap on half consumption
        drive_pair(32'h8800_0001, 32'h8800_0002, 32'hFFFF_FFFC);
        step();
        in_valid = 1'b0;
        take = 2'b01;
        step();
        take = 2'b00;
        chk("pcwrap_pc", out_pc, 32'h0000_0000);
        chk("pcwrap_inst1", out_inst1, 32'h8800_0002);

        // take=11 acts as none
        take = 2'b11;
        step();
        take = 2'b00;
        chk("take11_count", 32'(count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
